nios_jtag_scan_master: RTL and testbench

- Initiator for the Nios II JTAG debug module's virtual-JTAG interface.
- Generates the tck/tdi/ir_in and virtual-state strobes that the debug module's tck-side logic consumes, and captures its tdo. One command runs one scan: IR select, then a full DR shift.
- Used as a simulation stimulus source and as an on-chip debug-host bridge in place of the sld_virtual_jtag_basic hub.
- Runs entirely from the system clock; tck is a divided, registered output.

---
 rtl/nios_jtag_scan_master.sv | 163 ++++++++++++++++
 tb/tb_nios_jtag_scan_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_jtag_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug module: one command runs
// an IR select followed by a full DR shift, all timed from the system clock.
module nios_jtag_scan_master #(
   parameter int CLK_DIV = 2,
   parameter int DR_LEN  = 38,
   parameter int IR_W    = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [IR_W-1:0]   cmd_ir,
   input  logic [DR_LEN-1:0] cmd_dr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DR_LEN-1:0] rsp_data,
   output logic              tck,
   output logic              tdi,
   input  logic              tdo,
   output logic [IR_W-1:0]   ir_in,
   output logic              vs_uir,
   output logic              vs_cdr,
   output logic              vs_sdr,
   output logic              vs_udr,
   output logic              jtag_state_rti,
   output logic              busy
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = $clog2(DR_LEN + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UIR  = 3'd1,
      CDR  = 3'd2,
      SDR  = 3'd3,
      UDR  = 3'd4,
      RTI  = 3'd5,
      DONE = 3'd6
   } state_t;

   state_t            state_r;
   logic [DIV_W-1:0]  div_r;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic [DR_LEN-1:0] sr_r;
   logic              wrap_s;
   logic              rise_s;
   logic              fall_s;

   // Divider wrap decode; rise/fall name the tck edge this wrap produces.
   always_comb begin
      wrap_s = 1'b0;
      case (state_r)
         UIR, CDR, SDR, UDR, RTI: wrap_s = (div_r == DIV_W'(CLK_DIV - 1));
         default:                 wrap_s = 1'b0;
      endcase
      rise_s = wrap_s & ~tck;
      fall_s = wrap_s & tck;
   end

   // Scan sequencer with registered strobes, shift register and response.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r        <= IDLE;
         div_r          <= {DIV_W{1'b0}};
         bit_cnt_r      <= {CNT_W{1'b0}};
         sr_r           <= {DR_LEN{1'b0}};
         tck            <= 1'b0;
         tdi            <= 1'b0;
         ir_in          <= {IR_W{1'b0}};
         vs_uir         <= 1'b0;
         vs_cdr         <= 1'b0;
         vs_sdr         <= 1'b0;
         vs_udr         <= 1'b0;
         jtag_state_rti <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_data       <= {DR_LEN{1'b0}};
         cmd_ready      <= 1'b1;
         busy           <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  state_r   <= UIR;
                  ir_in     <= cmd_ir;
                  sr_r      <= cmd_dr;
                  div_r     <= {DIV_W{1'b0}};
                  tck       <= 1'b0;
                  vs_uir    <= 1'b1;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            UIR, CDR, SDR, UDR, RTI: begin
               if (wrap_s) begin
                  div_r <= {DIV_W{1'b0}};
                  tck   <= ~tck;
               end else begin
                  div_r <= div_r + DIV_W'(1);
               end
               // Target drives tdo for capture on the rising tck edge.
               if (rise_s && (state_r == SDR)) begin
                  sr_r      <= {tdo, sr_r[DR_LEN-1:1]};
                  bit_cnt_r <= bit_cnt_r + CNT_W'(1);
               end
               if (fall_s) begin
                  case (state_r)
                     UIR: begin
                        state_r <= CDR;
                        vs_uir  <= 1'b0;
                        vs_cdr  <= 1'b1;
                     end
                     CDR: begin
                        state_r <= SDR;
                        vs_cdr  <= 1'b0;
                        vs_sdr  <= 1'b1;
                        tdi     <= sr_r[0];
                     end
                     SDR: begin
                        if (bit_cnt_r == CNT_W'(DR_LEN)) begin
                           state_r   <= UDR;
                           vs_sdr    <= 1'b0;
                           vs_udr    <= 1'b1;
                           tdi       <= 1'b0;
                           bit_cnt_r <= {CNT_W{1'b0}};
                        end else begin
                           tdi <= sr_r[0];
                        end
                     end
                     UDR: begin
                        state_r        <= RTI;
                        vs_udr         <= 1'b0;
                        jtag_state_rti <= 1'b1;
                     end
                     RTI: begin
                        state_r        <= DONE;
                        jtag_state_rti <= 1'b0;
                        busy           <= 1'b0;
                     end
                     default: state_r <= IDLE;
                  endcase
               end
            end
            DONE: begin
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= sr_r;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_r   <= IDLE;
                  cmd_ready <= 1'b1;
               end
            end
            default: begin
               state_r   <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nios_jtag_scan_master.sv
// Directed bench for nios_jtag_scan_master: a CLK_DIV=2 instance for the main
// scenarios and a CLK_DIV=1 instance for the fast-divider capture case.
module tb_nios_jtag_scan_master;
   localparam int DR_LEN = 38;
   localparam int IR_W   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   int   checks   = 0;
   int   failures = 0;

   // instance a: CLK_DIV=2
   logic              cmd_valid, cmd_ready, rsp_valid, rsp_ready;
   logic [IR_W-1:0]   cmd_ir, ir_in;
   logic [DR_LEN-1:0] cmd_dr, rsp_data;
   logic              tck, tdi, tdo_loop, tdo_val;
   logic              vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, busy;
   wire               tdo = tdo_loop ? tdi : tdo_val;

   // instance b: CLK_DIV=1
   logic              cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b;
   logic [IR_W-1:0]   cmd_ir_b, ir_in_b;
   logic [DR_LEN-1:0] cmd_dr_b, rsp_data_b;
   logic              tck_b, tdi_b, tdo_b;
   logic              vs_uir_b, vs_cdr_b, vs_sdr_b, vs_udr_b, rti_b, busy_b;

   nios_jtag_scan_master #(.CLK_DIV(2), .DR_LEN(DR_LEN), .IR_W(IR_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
      .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
      .jtag_state_rti(jtag_state_rti), .busy(busy)
   );

   nios_jtag_scan_master #(.CLK_DIV(1), .DR_LEN(DR_LEN), .IR_W(IR_W)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir_b), .cmd_dr(cmd_dr_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
      .tck(tck_b), .tdi(tdi_b), .tdo(tdo_b), .ir_in(ir_in_b),
      .vs_uir(vs_uir_b), .vs_cdr(vs_cdr_b), .vs_sdr(vs_sdr_b), .vs_udr(vs_udr_b),
      .jtag_state_rti(rti_b), .busy(busy_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // accept on instance a; returns with the accept edge (edge 0) just sampled
   task automatic accept_a(input logic [IR_W-1:0] ir, input logic [DR_LEN-1:0] dr);
      cmd_ir    = ir;
      cmd_dr    = dr;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] outs;
      reset_n     = 1'b0;
      cmd_valid   = 1'b1;
      cmd_valid_b = 1'b1;
      repeat (3) tick();
      outs = {tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, rsp_valid, busy};
      checks++;
      if (outs !== 11'd0) begin
         failures++;
         $display("FAIL reset_outs got=%b exp=%b", outs, 11'd0);
      end
      checks++;
      if (rsp_data !== {DR_LEN{1'b0}}) begin
         failures++;
         $display("FAIL reset_rsp_data got=%h exp=0", rsp_data);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
      end
      outs = {tck_b, tdi_b, ir_in_b, vs_uir_b, vs_cdr_b, vs_sdr_b, vs_udr_b, rti_b, rsp_valid_b, busy_b};
      checks++;
      if (outs !== 11'd0 || cmd_ready_b !== 1'b1) begin
         failures++;
         $display("FAIL reset_b_outs got=%b rdy=%b exp=0 rdy=1", outs, cmd_ready_b);
      end
      cmd_valid   = 1'b0;
      cmd_valid_b = 1'b0;
      reset_n     = 1'b1;
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || vs_uir !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_accept got rdy=%b busy=%b uir=%b exp 1 0 0", cmd_ready, busy, vs_uir);
      end
   endtask

   task automatic test_loopback();
      int rise_e = 0;
      tdo_loop = 1'b1;
      accept_a(2'b01, 38'h2A_5A5A_C3C3);
      checks++;
      if (ir_in !== 2'b01 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL loop_accept got ir=%b rdy=%b busy=%b exp 01 0 1", ir_in, cmd_ready, busy);
      end
      for (int e = 1; e <= 300; e++) begin
         tick();
         if (rsp_valid) begin
            rise_e = e;
            break;
         end
      end
      checks++;
      if (rise_e != 169) begin
         failures++;
         $display("FAIL loop_latency got=%0d exp=169", rise_e);
      end
      checks++;
      if (rsp_data !== 38'h2A_5A5A_C3C3) begin
         failures++;
         $display("FAIL loop_data got=%h exp=%h", rsp_data, 38'h2A_5A5A_C3C3);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || ir_in !== 2'b01 || tck !== 1'b0) begin
         failures++;
         $display("FAIL loop_release got v=%b rdy=%b ir=%b tck=%b exp 0 1 01 0",
                  rsp_valid, cmd_ready, ir_in, tck);
      end
   endtask

   task automatic test_strobe_timing();
      int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
      int toggles = 0, bad_tog = 0, bad_oh = 0;
      logic prev_tck;
      logic [4:0] st;
      tdo_loop = 1'b0;
      tdo_val  = 1'b1;
      accept_a(2'b11, 38'h0);
      prev_tck = tck;
      for (int e = 0; e <= 300; e++) begin
         if (e > 0) tick();
         st = {vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti};
         n_uir += int'(vs_uir);
         n_cdr += int'(vs_cdr);
         n_sdr += int'(vs_sdr);
         n_udr += int'(vs_udr);
         n_rti += int'(jtag_state_rti);
         if (tck !== prev_tck) begin
            toggles++;
            if (e % 2 != 0) bad_tog++;
         end
         prev_tck = tck;
         if (busy && $countones(st) != 1) bad_oh++;
         if (!busy && st != 5'd0) bad_oh++;
         if (rsp_valid) break;
      end
      checks++;
      if (n_uir != 4 || n_cdr != 4 || n_udr != 4 || n_rti != 4) begin
         failures++;
         $display("FAIL strobe_short got uir=%0d cdr=%0d udr=%0d rti=%0d exp 4 each",
                  n_uir, n_cdr, n_udr, n_rti);
      end
      checks++;
      if (n_sdr != 152) begin
         failures++;
         $display("FAIL strobe_sdr got=%0d exp=152", n_sdr);
      end
      checks++;
      if (toggles != 84 || bad_tog != 0) begin
         failures++;
         $display("FAIL strobe_tck got toggles=%0d odd=%0d exp 84 0", toggles, bad_tog);
      end
      checks++;
      if (bad_oh != 0) begin
         failures++;
         $display("FAIL strobe_onehot got=%0d exp=0", bad_oh);
      end
      checks++;
      if (rsp_data !== {DR_LEN{1'b1}}) begin
         failures++;
         $display("FAIL strobe_data got=%h exp=all ones", rsp_data);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      int rise_e = 0;
      tdo_loop = 1'b1;
      accept_a(2'b01, 38'h15_A5A5_3C3C);
      for (int e = 1; e <= 300; e++) begin
         tick();
         if (rsp_valid) break;
      end
      cmd_ir    = 2'b10;
      cmd_dr    = 38'h0F_0000_FFFF;
      cmd_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_data !== 38'h15_A5A5_3C3C || cmd_ready !== 1'b0 || ir_in !== 2'b01)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL hold_stable got bad_cycles=%0d exp=0", bad);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || ir_in !== 2'b01) begin
         failures++;
         $display("FAIL hold_release got v=%b rdy=%b ir=%b exp 0 1 01", rsp_valid, cmd_ready, ir_in);
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (cmd_ready !== 1'b0 || ir_in !== 2'b10 || busy !== 1'b1) begin
         failures++;
         $display("FAIL next_accept got rdy=%b ir=%b busy=%b exp 0 10 1", cmd_ready, ir_in, busy);
      end
      for (int e = 1; e <= 300; e++) begin
         tick();
         if (rsp_valid) begin
            rise_e = e;
            break;
         end
      end
      checks++;
      if (rise_e != 169 || rsp_data !== 38'h0F_0000_FFFF) begin
         failures++;
         $display("FAIL next_scan got edge=%0d data=%h exp 169 %h", rise_e, rsp_data, 38'h0F_0000_FFFF);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_abort();
      int seen = 0;
      tdo_loop = 1'b1;
      accept_a(2'b00, 38'h3F_1234_5678);
      repeat (46) tick();
      checks++;
      if (vs_sdr !== 1'b1) begin
         failures++;
         $display("FAIL abort_in_sdr got=%b exp=1", vs_sdr);
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      checks++;
      if (tck !== 1'b0 || vs_sdr !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || tdi !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle got tck=%b sdr=%b rdy=%b busy=%b tdi=%b exp 0 0 1 0 0",
                  tck, vs_sdr, cmd_ready, busy, tdi);
      end
      for (int i = 0; i < 250; i++) begin
         tick();
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL abort_no_rsp got bad_cycles=%0d exp=0", seen);
      end
   endtask

   task automatic test_clkdiv1();
      logic [DR_LEN-1:0] pat;
      int rise_e = 0;
      int early = 0;
      for (int i = 0; i < DR_LEN; i++) pat[i] = (i % 4 == 0) || (i % 4 == 3);
      tdo_b       = 1'b0;
      cmd_ir_b    = 2'b10;
      cmd_dr_b    = 38'h00_FFFF_0000;
      cmd_valid_b = 1'b1;
      tick();
      cmd_valid_b = 1'b0;
      for (int e = 1; e <= 200; e++) begin
         if (e % 2 == 1 && e >= 5 && e <= 79) tdo_b = pat[(e - 5) / 2];
         else tdo_b = 1'b0;
         tick();
         if (e == 84 && rsp_valid_b !== 1'b0) early++;
         if (rsp_valid_b) begin
            rise_e = e;
            break;
         end
      end
      checks++;
      if (rise_e != 85 || early != 0) begin
         failures++;
         $display("FAIL div1_latency got=%0d early=%0d exp=85", rise_e, early);
      end
      checks++;
      if (rsp_data_b !== pat) begin
         failures++;
         $display("FAIL div1_data got=%h exp=%h", rsp_data_b, pat);
      end
      rsp_ready_b = 1'b1;
      tick();
      rsp_ready_b = 1'b0;
      checks++;
      if (cmd_ready_b !== 1'b1 || rsp_valid_b !== 1'b0 || ir_in_b !== 2'b10) begin
         failures++;
         $display("FAIL div1_release got rdy=%b v=%b ir=%b exp 1 0 10", cmd_ready_b, rsp_valid_b, ir_in_b);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_ir      = 2'b00;
      cmd_dr      = {DR_LEN{1'b0}};
      rsp_ready   = 1'b0;
      tdo_loop    = 1'b0;
      tdo_val     = 1'b0;
      cmd_valid_b = 1'b0;
      cmd_ir_b    = 2'b00;
      cmd_dr_b    = {DR_LEN{1'b0}};
      rsp_ready_b = 1'b0;
      tdo_b       = 1'b0;
      test_reset();
      test_loopback();
      test_strobe_timing();
      test_back_to_back();
      test_abort();
      test_clkdiv1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
